// File: rtl/cr16_pkg.sv
// Shared definitions for the cr16 execute controller, its register file and ALU.
// Holds ALU opcodes, status bit indices, instruction class codes and FSM states.
// Helper functions classify instruction words for the decoder.
package cr16_pkg;

    // ALU opcodes driven on the 4-bit opcode bus
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_ADDU  = 4'd1;
    localparam logic [3:0] ALU_ADDC  = 4'd2;
    localparam logic [3:0] ALU_ADDCU = 4'd3;
    localparam logic [3:0] ALU_SUB   = 4'd4;
    localparam logic [3:0] ALU_SUBC  = 4'd5;
    localparam logic [3:0] ALU_AND   = 4'd6;
    localparam logic [3:0] ALU_OR    = 4'd7;
    localparam logic [3:0] ALU_XOR   = 4'd8;
    localparam logic [3:0] ALU_NOT   = 4'd9;
    localparam logic [3:0] ALU_LSH   = 4'd10;
    localparam logic [3:0] ALU_RSH   = 4'd11;
    localparam logic [3:0] ALU_ALSH  = 4'd12;
    localparam logic [3:0] ALU_ARSH  = 4'd13;

    // Status / PSR bit positions, {N,Z,F,L,C}
    localparam int STAT_CARRY    = 0;
    localparam int STAT_LOW      = 1;
    localparam int STAT_FLAG     = 2;
    localparam int STAT_ZERO     = 3;
    localparam int STAT_NEGATIVE = 4;

    // Instruction class codes, instr[15:12]
    localparam logic [3:0] CLS_RTYPE = 4'd0;
    localparam logic [3:0] CLS_ADDI  = 4'd1;
    localparam logic [3:0] CLS_SUBI  = 4'd2;
    localparam logic [3:0] CLS_ANDI  = 4'd3;
    localparam logic [3:0] CLS_ORI   = 4'd4;
    localparam logic [3:0] CLS_MOVI  = 4'd5;
    localparam logic [3:0] CLS_LUI   = 4'd6;
    localparam logic [3:0] CLS_CMP   = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    // Classes 8-15 and R-type with ext 14/15 are undefined.
    function automatic logic is_illegal(input logic [15:0] instr);
        return instr[15] || ((instr[15:12] == CLS_RTYPE) && (instr[7:4] > ALU_ARSH));
    endfunction

    // MOVI and LUI complete without the ALU.
    function automatic logic uses_alu(input logic [3:0] cls);
        return !((cls == CLS_MOVI) || (cls == CLS_LUI));
    endfunction

endpackage

// File: rtl/cr16_alu.sv
// Registered cr16 ALU: result and {N,Z,F,L,C} status captured on an enabled edge.
// Latency: 1 cycle from enable to valid c/status; outputs hold until the next enable.
// Backpressure: none. Ports: clk, reset, enable, opcode, a, b -> c, status.
module cr16_alu
    import cr16_pkg::*;
#(
    parameter int P_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         opcode,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] c,
    output logic [4:0]         status
);

    localparam int MSB = P_WIDTH - 1;

    logic [P_WIDTH:0]   ext_sum;
    logic [P_WIDTH-1:0] res;
    logic               ci;
    logic               cy;
    logic               ovf;
    logic               low;
    logic [4:0]         st_nxt;

    always_comb begin
        ext_sum = '0;
        res     = '0;
        ci      = 1'b0;
        cy      = 1'b0;
        ovf     = 1'b0;
        low     = 1'b0;
        case (opcode)
            ALU_ADD, ALU_ADDU, ALU_ADDC, ALU_ADDCU: begin
                ci      = ((opcode == ALU_ADDC) || (opcode == ALU_ADDCU)) && status[STAT_CARRY];
                ext_sum = {1'b0, b} + {1'b0, a} + {{P_WIDTH{1'b0}}, ci};
                res     = ext_sum[MSB:0];
                cy      = ext_sum[P_WIDTH];
                // Unsigned variants never raise the overflow flag
                ovf     = ((opcode == ALU_ADD) || (opcode == ALU_ADDC)) &&
                          (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            ALU_SUB, ALU_SUBC: begin
                // Subtract computes b - a so the destination register sits on b
                ci      = (opcode == ALU_SUBC) && status[STAT_CARRY];
                ext_sum = {1'b0, b} - {1'b0, a} - {{P_WIDTH{1'b0}}, ci};
                res     = ext_sum[MSB:0];
                cy      = ext_sum[P_WIDTH];
                ovf     = (a[MSB] != b[MSB]) && (res[MSB] != b[MSB]);
                low     = (b < a);
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOT:  res = ~a;
            ALU_LSH:  res = a << b[3:0];
            ALU_RSH:  res = a >> b[3:0];
            ALU_ALSH: res = a << b[3:0];
            ALU_ARSH: res = P_WIDTH'($signed(a) >>> b[3:0]);
            default:  res = '0;
        endcase

        st_nxt                = '0;
        st_nxt[STAT_CARRY]    = cy;
        st_nxt[STAT_LOW]      = low;
        st_nxt[STAT_FLAG]     = ovf;
        st_nxt[STAT_ZERO]     = (res == '0);
        st_nxt[STAT_NEGATIVE] = res[MSB];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c      <= '0;
            status <= '0;
        end else if (enable) begin
            c      <= res;
            status <= st_nxt;
        end
    end

endmodule

// File: rtl/cr16_regfile.sv
// 16 x P_WIDTH register file: three combinational reads (rs, rd, debug), one write.
// Latency: reads 0 cycles, write visible the cycle after the write edge.
// Backpressure: none; the write port is always accepted. Ports: clk, reset, read addr/data, we/waddr/wdata.
module cr16_regfile #(
    parameter int P_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         rs_addr,
    input  logic [3:0]         rd_addr,
    input  logic [3:0]         dbg_addr,
    output logic [P_WIDTH-1:0] rs_data,
    output logic [P_WIDTH-1:0] rd_data,
    output logic [P_WIDTH-1:0] dbg_data,
    input  logic               we,
    input  logic [3:0]         waddr,
    input  logic [P_WIDTH-1:0] wdata
);

    logic [P_WIDTH-1:0] regs [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs_data  = regs[rs_addr];
    assign rd_data  = regs[rd_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/cr16_exec_ctrl.sv
// Multi-cycle execute controller feeding cr16_alu from a 16-entry register file.
// Latency: ALU ops 4 cycles handshake-to-ready, MOVI/LUI 3, illegal 2; one instruction in flight.
// Backpressure: O_INSTR_READY only in IDLE and never during reset; valid held high is accepted once per IDLE.
// Ports: instruction valid/ready/word, ALU enable/opcode/A/B out, ALU C/status in, PSR, illegal flag, debug read.
module cr16_exec_ctrl
    import cr16_pkg::*;
#(
    parameter int P_WIDTH = 16   // must be >= 16
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               I_INSTR_VALID,
    output logic               O_INSTR_READY,
    input  logic [15:0]        I_INSTR,
    output logic               O_ALU_ENABLE,
    output logic [3:0]         O_ALU_OPCODE,
    output logic [P_WIDTH-1:0] O_ALU_A,
    output logic [P_WIDTH-1:0] O_ALU_B,
    input  logic [P_WIDTH-1:0] I_ALU_C,
    input  logic [4:0]         I_ALU_STATUS,
    output logic [4:0]         O_PSR,
    output logic               O_ILLEGAL,
    input  logic [3:0]         I_DBG_ADDR,
    output logic [P_WIDTH-1:0] O_DBG_DATA
);

    state_t state;
    state_t state_nxt;

    logic [15:0] ir;
    logic [3:0]  cls;
    logic [3:0]  rd_idx;
    logic [3:0]  ext;
    logic [3:0]  rs_idx;
    logic [7:0]  imm8;

    logic [P_WIDTH-1:0] rs_data;
    logic [P_WIDTH-1:0] rd_data;
    logic               rf_we;
    logic [P_WIDTH-1:0] rf_wdata;
    logic               psr_we;
    logic               handshake;

    logic [15:0]        sext16;
    logic [15:0]        lui16;
    logic [P_WIDTH-1:0] imm_sext;
    logic [P_WIDTH-1:0] imm_zext;
    logic [P_WIDTH-1:0] imm_result;
    logic [3:0]         dec_opcode;
    logic [P_WIDTH-1:0] dec_a;
    logic [P_WIDTH-1:0] dec_b;
    logic               dec_illegal;

    assign cls    = ir[15:12];
    assign rd_idx = ir[11:8];
    assign ext    = ir[7:4];
    assign rs_idx = ir[3:0];
    assign imm8   = ir[7:0];

    cr16_regfile #(
        .P_WIDTH (P_WIDTH)
    ) u_regfile (
        .clk      (I_CLK),
        .reset    (I_RESET),
        .rs_addr  (rs_idx),
        .rd_addr  (rd_idx),
        .dbg_addr (I_DBG_ADDR),
        .rs_data  (rs_data),
        .rd_data  (rd_data),
        .dbg_data (O_DBG_DATA),
        .we       (rf_we && !I_RESET),
        .waddr    (rd_idx),
        .wdata    (rf_wdata)
    );

    // Immediates are formed at 16 bits, then zero-filled above bit 15.
    assign sext16   = {{8{imm8[7]}}, imm8};
    assign imm_sext = P_WIDTH'(sext16);
    assign imm_zext = P_WIDTH'(imm8);
    // LUI keeps the low byte of Rd; the register file is stable until WB, so read it there.
    assign lui16      = {imm8, rd_data[7:0]};
    assign imm_result = (cls == CLS_LUI) ? P_WIDTH'(lui16) : imm_zext;

    assign dec_illegal   = is_illegal(ir);
    assign handshake     = I_INSTR_VALID && O_INSTR_READY;
    assign O_INSTR_READY = (state == S_IDLE) && !I_RESET;

    // Operand selection for the DECODE-cycle register load
    always_comb begin
        dec_opcode = ALU_ADD;
        dec_a      = '0;
        dec_b      = rd_data;
        case (cls)
            CLS_RTYPE: begin
                dec_opcode = ext;
                // Shifts take the value from Rd and the amount from Rs
                if (ext >= ALU_LSH) begin
                    dec_a = rd_data;
                    dec_b = rs_data;
                end else begin
                    dec_a = rs_data;
                    dec_b = rd_data;
                end
            end
            CLS_ADDI: begin
                dec_opcode = ALU_ADD;
                dec_a      = imm_sext;
            end
            CLS_SUBI: begin
                dec_opcode = ALU_SUB;
                dec_a      = imm_sext;
            end
            CLS_ANDI: begin
                dec_opcode = ALU_AND;
                dec_a      = imm_zext;
            end
            CLS_ORI: begin
                dec_opcode = ALU_OR;
                dec_a      = imm_zext;
            end
            CLS_CMP: begin
                // Opcode is forced to SUB, so ext only matters for legality of R-type;
                // compare always evaluates Rd - Rs.
                dec_opcode = ALU_SUB;
                dec_a      = rs_data;
                dec_b      = rd_data;
            end
            default: begin
                dec_opcode = ALU_ADD;
            end
        endcase
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nxt    = state;
        O_ALU_ENABLE = 1'b0;
        O_ILLEGAL    = 1'b0;
        rf_we        = 1'b0;
        rf_wdata     = '0;
        psr_we       = 1'b0;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    O_ILLEGAL = 1'b1;
                    state_nxt = S_IDLE;
                end else if (!uses_alu(cls)) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                O_ALU_ENABLE = 1'b1;
                state_nxt    = S_WB;
            end
            S_WB: begin
                state_nxt = S_IDLE;
                if (!uses_alu(cls)) begin
                    rf_we    = 1'b1;
                    rf_wdata = imm_result;
                end else begin
                    psr_we   = 1'b1;
                    rf_we    = (cls != CLS_CMP);
                    rf_wdata = I_ALU_C;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state        <= S_IDLE;
            ir           <= '0;
            O_PSR        <= '0;
            O_ALU_OPCODE <= '0;
            O_ALU_A      <= '0;
            O_ALU_B      <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                ir <= I_INSTR;
            end
            // ALU-facing registers change only in DECODE and hold otherwise
            if (state == S_DECODE) begin
                O_ALU_OPCODE <= dec_opcode;
                O_ALU_A      <= dec_a;
                O_ALU_B      <= dec_b;
            end
            if (psr_we) begin
                O_PSR <= I_ALU_STATUS;
            end
        end
    end

endmodule

// File: tb/tb_cr16_exec_ctrl.sv
module tb_cr16_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [15:0] instr;
    logic        rdy;
    logic        alu_en;
    logic [3:0]  alu_opc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_c;
    logic [4:0]  alu_st;
    logic [4:0]  psr;
    logic        ill;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int cmps  = 0;
    int fails = 0;

    // Per-instruction observations gathered by do_instr
    int          lat;
    int          en_cnt;
    int          ill_cnt;
    int          ill_cyc;
    logic [3:0]  en_opc;
    logic [15:0] en_a;
    logic [15:0] en_b;
    int          acc;
    int          n;

    always #5 clk = ~clk;

    cr16_exec_ctrl #(.P_WIDTH(16)) dut (
        .I_CLK         (clk),
        .I_RESET       (rst),
        .I_INSTR_VALID (vld),
        .O_INSTR_READY (rdy),
        .I_INSTR       (instr),
        .O_ALU_ENABLE  (alu_en),
        .O_ALU_OPCODE  (alu_opc),
        .O_ALU_A       (alu_a),
        .O_ALU_B       (alu_b),
        .I_ALU_C       (alu_c),
        .I_ALU_STATUS  (alu_st),
        .O_PSR         (psr),
        .O_ILLEGAL     (ill),
        .I_DBG_ADDR    (dbg_addr),
        .O_DBG_DATA    (dbg_data)
    );

    cr16_alu #(.P_WIDTH(16)) u_alu (
        .clk    (clk),
        .reset  (rst),
        .enable (alu_en),
        .opcode (alu_opc),
        .a      (alu_a),
        .b      (alu_b),
        .c      (alu_c),
        .status (alu_st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!rdy && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!rdy) begin
            cmps++;
            fails++;
            $error("FAIL ready_timeout: observed 0 expected 1");
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    // Handshake one instruction, then count cycles until ready returns.
    // Cycle 1 is the DECODE cycle following the accepting edge.
    task automatic do_instr(input logic [15:0] ins);
        int c;
        wait_ready();
        vld   = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        vld     = 1'b0;
        c       = 1;
        en_cnt  = 0;
        ill_cnt = 0;
        ill_cyc = -1;
        while (c < 50) begin
            if (alu_en) begin
                en_cnt++;
                en_opc = alu_opc;
                en_a   = alu_a;
                en_b   = alu_b;
            end
            if (ill) begin
                ill_cnt++;
                ill_cyc = c;
            end
            if (rdy) break;
            @(posedge clk);
            #1;
            c++;
        end
        lat = c;
    endtask

    initial begin
        rst      = 1'b1;
        vld      = 1'b0;
        instr    = 16'h0;
        dbg_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_ready", rdy, 0);
        chk("rst_psr", psr, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_illegal", ill, 0);
        chk("rst_opcode", alu_opc, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk_reg("rst_r0", 4'd0, 16'h0000);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", rdy, 1);

        // MOVI R1,5 ; MOVI R2,3
        do_instr(16'h5105);
        chk("movi_r1_lat", lat, 3);
        chk("movi_r1_noalu", en_cnt, 0);
        chk_reg("movi_r1", 4'd1, 16'h0005);
        do_instr(16'h5203);
        chk_reg("movi_r2", 4'd2, 16'h0003);

        // R-type SUB Rd=R1, Rs=R2 : R1 = 5 - 3
        do_instr(16'h0142);
        chk("sub_lat", lat, 4);
        chk("sub_en_cnt", en_cnt, 1);
        chk("sub_opcode", en_opc, 4);
        chk("sub_a", en_a, 16'h0003);
        chk("sub_b", en_b, 16'h0005);
        chk_reg("sub_r1", 4'd1, 16'h0002);
        chk("sub_psr", psr, 5'b00000);
        chk("sub_no_illegal", ill_cnt, 0);

        // CMP Rd=R1 (2), Rs=R2 (3): negative result, no write
        do_instr(16'h7102);
        chk("cmp_lat", lat, 4);
        chk("cmp_psr_n", psr[4], 1);
        chk_reg("cmp_r1_kept", 4'd1, 16'h0002);

        // MOVI R3,0x34 ; LUI R3,0x12 from reset, PSR stays 0
        pulse_reset();
        do_instr(16'h5334);
        chk("movi_r3_lat", lat, 3);
        do_instr(16'h6312);
        chk("lui_lat", lat, 3);
        chk("lui_noalu", en_cnt, 0);
        chk_reg("lui_r3", 4'd3, 16'h1234);
        chk("lui_psr", psr, 5'b00000);

        // ADDI R3,0xFF from reset: sign-extended -1
        pulse_reset();
        do_instr(16'h13FF);
        chk("addi_opcode", en_opc, 0);
        chk("addi_a", en_a, 16'hFFFF);
        chk("addi_b", en_b, 16'h0000);
        chk_reg("addi_r3", 4'd3, 16'hFFFF);
        chk("addi_psr_n", psr[4], 1);
        chk("addi_psr_f", psr[2], 0);

        // Illegal class 8
        do_instr(16'h8000);
        chk("ill8_lat", lat, 2);
        chk("ill8_cnt", ill_cnt, 1);
        chk("ill8_cyc", ill_cyc, 1);
        chk("ill8_noalu", en_cnt, 0);
        chk("ill8_psr_kept", psr[4], 1);
        chk_reg("ill8_r0", 4'd0, 16'h0000);

        // Illegal R-type ext 0xE on Rd=R3
        do_instr(16'h03E1);
        chk("illE_lat", lat, 2);
        chk("illE_cnt", ill_cnt, 1);
        chk("illE_cyc", ill_cyc, 1);
        chk_reg("illE_r3_kept", 4'd3, 16'hFFFF);
        chk("illE_psr_kept", psr[4], 1);

        // ADDI R4,1 aborted by reset during EXEC
        wait_ready();
        vld   = 1'b1;
        instr = 16'h1401;
        @(posedge clk);
        #1;
        vld = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_exec_en", alu_en, 1);
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst", rdy, 0);
        @(posedge clk);
        #1;
        chk("abort_en_cleared", alu_en, 0);
        chk("abort_psr", psr, 5'b00000);
        chk("abort_ready_held", rdy, 0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", rdy, 1);
        @(posedge clk);
        #1;
        chk_reg("abort_r4", 4'd4, 16'h0000);
        chk_reg("abort_r3", 4'd3, 16'h0000);

        // Valid held high for 10 cycles with ADDI R5,1: accepted at cycles 0, 4, 8
        vld   = 1'b1;
        instr = 16'h1501;
        acc   = 0;
        for (int i = 0; i < 10; i++) begin
            if (rdy) acc++;
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
        chk("hold_accepts", acc, 3);
        n = 0;
        while (!rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_drain_ready", rdy, 1);
        chk_reg("hold_r5", 4'd5, 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end

endmodule
